id_stage: RTL and testbench

- Decode stage of the 5-stage RV32I pipeline. Sits directly downstream of the fetch stage and consumes its `if_id_t` bundle.
- Owns the architectural register file (32x32, x0 hardwired zero). Decodes opcode, funct3 and funct7 into control signals and generates the sign-extended immediate.
- Drives a registered `id_ex_t` bundle into execute.
- Accepts the write-back port from the final stage, and stall/flush controls from the hazard unit.

---
 rtl/riscv_pkg.sv | 80 ++++++++
 rtl/regfile.sv | 37 +++
 rtl/id_stage.sv | 139 +++++++++++++
 tb/tb_id_stage.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I types, opcodes and decode helpers for the pipeline.
package riscv_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_e;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_e;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    alu_op_e     alu_op;
    logic        alu_src_imm;
    logic        alu_src_pc;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  funct3;
    logic        reg_wr;
    wb_sel_e     wb_sel;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic        illegal;
  } id_ex_t;

  // Sign-extended immediate for each encoding format.
  function automatic logic [31:0] gen_imm(input logic [31:0] i, input imm_fmt_e f);
    case (f)
      IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   return {i[31:12], 12'b0};
      IMM_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return {{20{i[31]}}, i[31:20]};
    endcase
  endfunction

  // ALU op from funct3; alt selects SUB/SRA where the encoding allows it.
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/regfile.sv
// Architectural register file: 2 async reads, 1 sync write, x0 fixed at zero,
// same-cycle write-to-read bypass.
module regfile
  import riscv_pkg::*;
#(
  parameter int W  = 32,
  parameter int N  = 32,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [W-1:0]  rd1,
  output logic [W-1:0]  rd2,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0]  wd
);

  logic [N-1:0][W-1:0] regs;

  // Write port; reset clears every entry and masks the write that cycle.
  always_ff @(posedge clk) begin
    if (!rst_n)                  regs     <= '0;
    else if (we && wa != '0)     regs[wa] <= wd;
  end

  // Read ports see an in-flight write-back so decode never reads stale data.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ra1 != '0) rd1 = (we && wa == ra1) ? wd : regs[ra1];
    if (ra2 != '0) rd2 = (we && wa == ra2) ? wd : regs[ra2];
  end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: control decode, immediate generation, register read,
// and the registered id/ex bundle.
module id_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int NREGS = riscv_pkg::NREGS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall,
  input  logic                     flush,
  input  if_id_t                   in,
  input  logic                     wb_en,
  input  logic [$clog2(NREGS)-1:0] wb_rd,
  input  logic [XLEN-1:0]          wb_data,
  output logic [$clog2(NREGS)-1:0] rs1_addr,
  output logic [$clog2(NREGS)-1:0] rs2_addr,
  output id_ex_t                   out
);

  logic [6:0]              opc;
  logic [$clog2(NREGS)-1:0] rs1_rd;
  logic [XLEN-1:0]         rs1_val, rs2_val;
  id_ex_t                  dec;
  imm_fmt_e                fmt;

  assign opc      = in.instr[6:0];
  assign rs1_addr = in.instr[19:15];
  assign rs2_addr = in.instr[24:20];
  // LUI has no rs1; reading x0 keeps operand A at zero.
  assign rs1_rd   = (opc == OPC_LUI) ? '0 : rs1_addr;

  regfile #(.W(XLEN), .N(NREGS)) u_rf (
    .clk  (clk),
    .rst_n(rst_n),
    .ra1  (rs1_rd),
    .ra2  (rs2_addr),
    .rd1  (rs1_val),
    .rd2  (rs2_val),
    .we   (wb_en),
    .wa   (wb_rd),
    .wd   (wb_data)
  );

  // Opcode decode into control fields and immediate.
  always_comb begin
    dec         = '0;
    fmt         = IMM_I;
    dec.valid   = 1'b1;
    dec.pc      = in.pc;
    dec.pc4     = in.pc4;
    dec.rs1_val = rs1_val;
    dec.rs2_val = rs2_val;
    dec.rd      = in.instr[11:7];
    dec.funct3  = in.instr[14:12];
    dec.alu_op  = ALU_ADD;
    dec.wb_sel  = WB_ALU;
    case (opc)
      OPC_OP: begin
        dec.alu_op = alu_from_f3(in.instr[14:12], in.instr[30]);
        dec.reg_wr = 1'b1;
      end
      OPC_OP_IMM: begin
        // Bit 30 is immediate data except for the SRAI/SRLI encoding.
        dec.alu_op      = alu_from_f3(in.instr[14:12],
                                      (in.instr[14:12] == 3'b101) && in.instr[30]);
        dec.alu_src_imm = 1'b1;
        dec.reg_wr      = 1'b1;
        dec.imm         = gen_imm(in.instr, fmt);
      end
      OPC_LOAD: begin
        dec.alu_src_imm = 1'b1;
        dec.mem_rd      = 1'b1;
        dec.reg_wr      = 1'b1;
        dec.wb_sel      = WB_MEM;
        dec.imm         = gen_imm(in.instr, fmt);
      end
      OPC_STORE: begin
        fmt             = IMM_S;
        dec.alu_src_imm = 1'b1;
        dec.mem_wr      = 1'b1;
        dec.rd          = '0;
        dec.imm         = gen_imm(in.instr, fmt);
      end
      OPC_BRANCH: begin
        fmt        = IMM_B;
        dec.alu_op = ALU_SUB;
        dec.branch = 1'b1;
        dec.rd     = '0;
        dec.imm    = gen_imm(in.instr, fmt);
      end
      OPC_JAL: begin
        fmt        = IMM_J;
        dec.jal    = 1'b1;
        dec.reg_wr = 1'b1;
        dec.wb_sel = WB_PC4;
        dec.imm    = gen_imm(in.instr, fmt);
      end
      OPC_JALR: begin
        dec.alu_src_imm = 1'b1;
        dec.jalr        = 1'b1;
        dec.reg_wr      = 1'b1;
        dec.wb_sel      = WB_PC4;
        dec.imm         = gen_imm(in.instr, fmt);
      end
      OPC_LUI: begin
        fmt             = IMM_U;
        dec.alu_op      = ALU_PASSB;
        dec.alu_src_imm = 1'b1;
        dec.reg_wr      = 1'b1;
        dec.imm         = gen_imm(in.instr, fmt);
      end
      OPC_AUIPC: begin
        fmt             = IMM_U;
        dec.alu_src_imm = 1'b1;
        dec.alu_src_pc  = 1'b1;
        dec.reg_wr      = 1'b1;
        dec.imm         = gen_imm(in.instr, fmt);
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // Output register: reset > flush > stall > load; invalid input keeps pc only.
  always_ff @(posedge clk) begin
    if (!rst_n)       out <= '0;
    else if (flush)   out <= '0;
    else if (!stall) begin
      if (in.valid)   out <= dec;
      else begin
        out     <= '0;
        out.pc  <= in.pc;
        out.pc4 <= in.pc4;
      end
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: expected bundles queued at drive time,
// compared one cycle later.
module tb_id_stage;
  import riscv_pkg::*;

  localparam int W = $bits(id_ex_t);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  if_id_t      in_b;
  id_ex_t      out_b;
  logic [4:0]  rs1_addr, rs2_addr;

  id_ex_t sb_q[$];
  string  tag_q[$];
  id_ex_t last;
  int     checks = 0;
  int     errors = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .stall   (stall),
    .flush   (flush),
    .in      (in_b),
    .wb_en   (wb_en),
    .wb_rd   (wb_rd),
    .wb_data (wb_data),
    .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr),
    .out     (out_b)
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic id_ex_t bub(input logic [31:0] pc);
    id_ex_t e;
    e     = '0;
    e.pc  = pc;
    e.pc4 = pc + 32'd4;
    return e;
  endfunction

  // Expected bundle for an ALU-type instruction that writes rd.
  function automatic id_ex_t op(input logic [31:0] pc, input logic [2:0] f3,
                                input logic [4:0] rd, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] imm,
                                input alu_op_e alu, input logic si);
    id_ex_t e;
    e             = bub(pc);
    e.valid       = 1'b1;
    e.funct3      = f3;
    e.rd          = rd;
    e.rs1_val     = a;
    e.rs2_val     = b;
    e.imm         = imm;
    e.alu_op      = alu;
    e.alu_src_imm = si;
    e.reg_wr      = 1'b1;
    e.wb_sel      = WB_ALU;
    return e;
  endfunction

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr);
    in_b.valid = v;
    in_b.pc    = pc;
    in_b.pc4   = pc + 32'd4;
    in_b.instr = instr;
  endtask

  task automatic exp_push(input string tag, input id_ex_t e);
    sb_q.push_back(e);
    tag_q.push_back(tag);
    last = e;
  endtask

  task automatic wb(input logic en, input logic [4:0] rd, input logic [31:0] d);
    wb_en   = en;
    wb_rd   = rd;
    wb_data = d;
  endtask

  // Advance one clock and retire every queued expectation against out.
  task automatic tick();
    id_ex_t e;
    string  t;
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      chk(t, out_b, e);
    end
  endtask

  initial begin
    id_ex_t e;
    drive(1'b0, 32'h0, 32'h0);

    // Reset with a live write-back attempt.
    wb(1'b1, 5'd1, 32'h1234);
    exp_push("reset", '0); tick();

    // Write x1=5 while an invalid slot passes through.
    rst_n = 1'b1;
    wb(1'b1, 5'd1, 32'h5);
    drive(1'b0, 32'h100, 32'h0);
    exp_push("bubble_pc", bub(32'h100)); tick();

    // addi x2,x1,3
    wb(1'b0, 5'd0, 32'h0);
    drive(1'b1, 32'h104, 32'h00308113);
    #1;
    chk("rs_addr", W'({rs1_addr, rs2_addr}), W'({5'd1, 5'd3}));
    exp_push("addi", op(32'h104, 3'd0, 5'd2, 32'h5, 32'h0, 32'h3, ALU_ADD, 1'b1)); tick();

    // add x3,x1,x2 with same-cycle write of x1
    wb(1'b1, 5'd1, 32'hA5);
    drive(1'b1, 32'h108, 32'h002081B3);
    exp_push("bypass", op(32'h108, 3'd0, 5'd3, 32'hA5, 32'h0, 32'h0, ALU_ADD, 1'b0)); tick();

    // beq x1,x2,-8; park 0xDEAD in x8 for the LUI check
    wb(1'b1, 5'd8, 32'hDEAD);
    drive(1'b1, 32'h10C, 32'hFE208CE3);
    e         = bub(32'h10C);
    e.valid   = 1'b1;
    e.rs1_val = 32'hA5;
    e.imm     = 32'hFFFFFFF8;
    e.alu_op  = ALU_SUB;
    e.branch  = 1'b1;
    exp_push("beq", e); tick();

    // lui x5,0x12345 (rs1 field is x8, must read as 0)
    wb(1'b0, 5'd0, 32'h0);
    drive(1'b1, 32'h110, 32'h123452B7);
    exp_push("lui", op(32'h110, 3'd5, 5'd5, 32'h0, 32'h0, 32'h12345000, ALU_PASSB, 1'b1)); tick();

    // srai x6,x1,2
    drive(1'b1, 32'h114, 32'h4020D313);
    exp_push("srai", op(32'h114, 3'd5, 5'd6, 32'hA5, 32'h0, 32'h402, ALU_SRA, 1'b1)); tick();

    // Stall three cycles with changing input
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h180 + 32'(i * 4), 32'h002081B3 + 32'(i << 7));
      exp_push("stall_hold", last); tick();
    end

    // Flush wins over stall
    flush = 1'b1;
    exp_push("flush", '0); tick();
    stall = 1'b0;
    flush = 1'b0;

    // x0 write dropped and not bypassed: add x4,x0,x0
    wb(1'b1, 5'd0, 32'hFFFFFFFF);
    drive(1'b1, 32'h200, 32'h00000233);
    exp_push("x0_add", op(32'h200, 3'd0, 5'd4, 32'h0, 32'h0, 32'h0, ALU_ADD, 1'b0)); tick();

    // Illegal opcode
    wb(1'b0, 5'd0, 32'h0);
    drive(1'b1, 32'h204, 32'h0000007F);
    e         = bub(32'h204);
    e.valid   = 1'b1;
    e.illegal = 1'b1;
    exp_push("illegal", e); tick();

    // Fill x2, x3 then read x3 back
    wb(1'b1, 5'd2, 32'h22);
    drive(1'b0, 32'h208, 32'h0);
    exp_push("bubble_w2", bub(32'h208)); tick();
    wb(1'b1, 5'd3, 32'h33);
    drive(1'b0, 32'h20C, 32'h0);
    exp_push("bubble_w3", bub(32'h20C)); tick();
    wb(1'b0, 5'd0, 32'h0);
    drive(1'b1, 32'h210, 32'h0031E2B3);
    exp_push("or_pre", op(32'h210, 3'd6, 5'd5, 32'h33, 32'h33, 32'h0, ALU_OR, 1'b0)); tick();

    // Mid-stream reset discards the instruction and clears x1..x3
    rst_n = 1'b0;
    drive(1'b1, 32'h214, 32'h002081B3);
    exp_push("mid_reset", '0); tick();
    rst_n = 1'b1;
    drive(1'b1, 32'h218, 32'h0031E2B3);
    exp_push("or_post", op(32'h218, 3'd6, 5'd5, 32'h0, 32'h0, 32'h0, ALU_OR, 1'b0)); tick();
    drive(1'b1, 32'h21C, 32'h002081B3);
    exp_push("add_post", op(32'h21C, 3'd0, 5'd3, 32'h0, 32'h0, 32'h0, ALU_ADD, 1'b0)); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
